// File: rtl/nand4_response_checker.sv
// nand4_response_checker: checks a 4-input NAND DUT against a reference model,
// with coverage of all 16 input vectors, saturating counters and a final pass/fail.
module nand4_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  input  logic             in_d,
  input  logic             dut_e,
  input  logic             dut_f,
  input  logic             dut_g,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [15:0]      cover_mask,
  output logic [3:0]       first_fail_vec
);
  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, WAIT_CHG, DONE} state_t;
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] RELOAD = SW'(SETTLE_CYCLES - 1);
  state_t state;
  logic [3:0] v, last_v;
  logic [2:0] last_out;
  logic [SW-1:0] settle_cnt;
  logic changed, fail;
  logic [15:0] next_mask;
  assign v = {in_a, in_b, in_c, in_d};
  assign changed = v != last_v;
  // Check uses the vector and outputs registered on entry to CHECK, so a change mid-CHECK cannot skew it.
  assign fail = last_out != {~(last_v[3] & last_v[2]), ~(last_v[1] & last_v[0]), ~&last_v};
  assign next_mask = cover_mask | (16'd1 << last_v);
  assign busy = state == SETTLE || state == CHECK || state == WAIT_CHG;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_v         <= '0;
      last_out       <= '0;
      settle_cnt     <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch       <= 1'b0;
      err_count      <= '0;
      vec_count      <= '0;
      cover_mask     <= '0;
      first_fail_vec <= '0;
    end else begin
      last_v   <= v;
      last_out <= {dut_e, dut_f, dut_g};
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          done           <= 1'b0;
          pass           <= 1'b0;
          err_count      <= '0;
          vec_count      <= '0;
          cover_mask     <= '0;
          first_fail_vec <= '0;
          settle_cnt     <= RELOAD;
          state          <= SETTLE;
        end
        SETTLE: if (changed) settle_cnt <= RELOAD;
          else if (settle_cnt == '0) state <= CHECK;
          else settle_cnt <= settle_cnt - 1'b1;
        CHECK: begin
          vec_count  <= vec_count + CNT_W'(vec_count != '1);
          cover_mask <= next_mask;
          mismatch   <= fail;
          if (fail) begin
            err_count <= err_count + CNT_W'(err_count != '1);
            if (err_count == '0) first_fail_vec <= last_v;
          end
          if (next_mask == 16'hFFFF) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= !fail && err_count == '0;
          end else if (changed) begin
            settle_cnt <= RELOAD;
            state      <= SETTLE;
          end else state <= WAIT_CHG;
        end
        WAIT_CHG: if (changed) begin
          settle_cnt <= RELOAD;
          state      <= SETTLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nand4_response_checker.sv
// tb_nand4_response_checker: directed bench with a correct/faulty NAND model
// and a second narrow-counter instance whose g output is stuck at 0.
module tb_nand4_response_checker;
  logic clk = 0, rst = 0, start = 0, stuck_f = 0;
  logic [3:0] vec = 0;
  logic e, f, g;
  logic busy, done, pass, mismatch;
  logic [7:0] err_count, vec_count;
  logic [15:0] cover_mask;
  logic [3:0] first_fail_vec;
  logic s_busy, s_done, s_pass, s_mismatch;
  logic [3:0] s_err, s_vec, s_ffv;
  logic [15:0] s_mask;
  int tests = 0, fails = 0, mm_cnt = 0, mm0;

  always #5 clk = ~clk;

  assign e = ~(vec[3] & vec[2]);
  assign f = stuck_f ? 1'b1 : ~(vec[1] & vec[0]);
  assign g = ~&vec;

  nand4_response_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_a(vec[3]), .in_b(vec[2]), .in_c(vec[1]), .in_d(vec[0]),
    .dut_e(e), .dut_f(f), .dut_g(g), .start(start), .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .err_count(err_count), .vec_count(vec_count),
    .cover_mask(cover_mask), .first_fail_vec(first_fail_vec));

  nand4_response_checker #(.SETTLE_CYCLES(2), .CNT_W(4)) sat (
    .clk(clk), .rst(rst), .in_a(vec[3]), .in_b(vec[2]), .in_c(vec[1]), .in_d(vec[0]),
    .dut_e(e), .dut_f(~(vec[1] & vec[0])), .dut_g(1'b0), .start(start), .busy(s_busy),
    .done(s_done), .pass(s_pass), .mismatch(s_mismatch), .err_count(s_err),
    .vec_count(s_vec), .cover_mask(s_mask), .first_fail_vec(s_ffv));

  always @(negedge clk) if (mismatch) mm_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      vec = v;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic start_with(input logic [3:0] v);
    start = 1;
    hold(v, 1);
    start = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_idle", {busy, done, pass, mismatch}, 4'b0);
    chk("reset_counts", {err_count, vec_count, cover_mask, first_fail_vec}, 0);

    // reset in the middle of a run
    start_with(0);
    hold(0, 4);
    for (int v = 1; v < 5; v++) hold(4'(v), 5);
    hold(5, 1);
    chk("midrun_vec", vec_count, 5);
    chk("midrun_busy", busy, 1);
    rst = 1;
    #1;
    chk("midrun_rst_outs", {busy, done, pass, mismatch}, 4'b0);
    chk("midrun_rst_counts", {err_count, vec_count, cover_mask, first_fail_vec}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("midrun_idle", busy, 0);

    // correct DUT, full ascending coverage
    mm0 = mm_cnt;
    start_with(0);
    chk("full_busy", busy, 1);
    hold(0, 4);
    for (int v = 1; v < 16; v++) hold(4'(v), 5);
    chk("full_done", done, 1);
    chk("full_pass", pass, 1);
    chk("full_busy_low", busy, 0);
    chk("full_vec", vec_count, 16);
    chk("full_err", err_count, 0);
    chk("full_mask", cover_mask, 16'hFFFF);
    chk("full_mm", mm_cnt - mm0, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("restart_clear", {done, pass, vec_count, cover_mask}, 0);
    chk("restart_busy", busy, 1);

    // f stuck at 1
    do_reset();
    stuck_f = 1;
    mm0 = mm_cnt;
    start_with(0);
    hold(0, 4);
    for (int v = 1; v < 16; v++) hold(4'(v), 5);
    chk("stuck_err", err_count, 4);
    chk("stuck_mm", mm_cnt - mm0, 4);
    chk("stuck_ffv", first_fail_vec, 4'b0011);
    chk("stuck_done", done, 1);
    chk("stuck_pass", pass, 0);
    chk("stuck_vec", vec_count, 16);
    stuck_f = 0;

    // short glitch on vector 5 is not checked
    do_reset();
    start_with(5);
    hold(5, 1);
    hold(6, 5);
    chk("glitch_vec", vec_count, 1);
    chk("glitch_mask", cover_mask, 16'h0040);
    chk("glitch_err", err_count, 0);

    // a vector held exactly SETTLE_CYCLES cycles never reaches CHECK
    hold(9, 2);
    hold(9, 0);
    hold(10, 1);
    chk("short_hold_mask", cover_mask, 16'h0040);

    // repeated vectors and ignored starts
    do_reset();
    start_with(0);
    hold(0, 4);
    start = 1;
    hold(1, 1);
    start = 0;
    hold(1, 2);
    start = 1;
    hold(1, 1);
    start = 0;
    hold(1, 1);
    hold(0, 5);
    hold(1, 5);
    chk("rep_vec", vec_count, 4);
    chk("rep_mask", cover_mask, 16'h0003);
    chk("rep_done", done, 0);
    chk("rep_busy", busy, 1);

    // saturation on the 4-bit instance with g stuck at 0
    do_reset();
    start_with(0);
    hold(0, 3);
    for (int i = 1; i < 20; i++) hold(4'(i % 2), 4);
    chk("sat_err", s_err, 15);
    chk("sat_vec", s_vec, 15);
    chk("sat_ffv", s_ffv, 0);
    chk("sat_done", s_done, 0);
    chk("sat_main_err", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nand4_response_checker.md
# nand4_response_checker

Self-checking response monitor for the four-input NAND exercise: the receiving end of the stimulus/DUT path. It samples the 4-bit input vector applied to the NAND DUT, waits for the DUT to settle, and compares the DUT's three outputs against a reference model. It also tracks coverage of all 16 input combinations, counts vectors and mismatches, and reports a final pass/fail once coverage is complete. It sits in the bench beside the DUT and consumes the same `a/b/c/d` stimulus and the DUT's `e/f/g` outputs.

## Interface
- `SETTLE_CYCLES`, default 2: number of cycles a vector must be stable before it is checked (≥1).
- `CNT_W`, default 8: width of the vector and error counters.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_a`, `in_b`, `in_c`, `in_d`  in  1 each  DUT input vector, synchronous to `clk`. Vector encoding is `v = {in_a,in_b,in_c,in_d}`, with `in_a` as MSB.
- `dut_e`, `dut_f`, `dut_g`  in  1 each  DUT outputs.
- `start`  in  1  one-cycle pulse; begins a check run.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  high when all 16 vectors are covered; held until the next `start` or reset.
- `pass`  out  1  valid while `done`=1; 1 iff `err_count`==0.
- `mismatch`  out  1  one-cycle pulse for each failing check.
- `err_count`  out  `CNT_W`  number of failing checks, saturating.
- `vec_count`  out  `CNT_W`  number of checks performed, saturating.
- `cover_mask`  out  16  bit `v` is set once vector `v` has been checked.
- `first_fail_vec`  out  4  vector of the first failing check in the run.

## Operation
- Reference model:
  - `exp_e = ~(a&b)`
  - `exp_f = ~(c&d)`
  - `exp_g = ~(a&b&c&d)`
  - A check fails if any of `e`, `f`, `g` differs from its expected value.
- Internal register `last_v` holds the previous cycle's vector. A vector change means `v != last_v`.
- States:
  - **IDLE**: `busy`=0. On `start`: clear the counters, `cover_mask`, `first_fail_vec` and `done`; load `settle_cnt = SETTLE_CYCLES - 1`; go to SETTLE.
  - **SETTLE**: if the vector changes, reload `settle_cnt` and stay in SETTLE. Else if `settle_cnt`==0, go to CHECK. Else decrement `settle_cnt`.
  - **CHECK** (one cycle):
    - Compare; increment `vec_count` (saturating); set `cover_mask[v]`.
    - On failure: increment `err_count` (saturating) and pulse `mismatch` next cycle. If this is the first failure of the run, capture `first_fail_vec = v`.
    - If the updated mask is 16'hFFFF, go to DONE; else go to WAIT_CHG.
    - A vector change during CHECK: the check still uses the registered vector; go to SETTLE.
  - **WAIT_CHG**: on a vector change, reload `settle_cnt` and go to SETTLE. A stable vector is never rechecked.
  - **DONE**: `done`=1 and `busy`=0; `pass` is held. `start` returns to the IDLE-start action, i.e. clear and go to SETTLE.
- A `start` arriving while `busy` is ignored.
- Re-checking an already-covered vector increments `vec_count` and may increment `err_count`; `cover_mask` is unchanged.
- Counter saturation: a counter that reaches `2^CNT_W - 1` holds that value.
- Reset clears every output to 0 and returns the FSM to IDLE, including mid-run.

## Timing
- `start` is sampled at edge N; `busy`=1 from edge N.
- A vector stable from edge N is checked in the CHECK cycle beginning at edge N+`SETTLE_CYCLES`.
- `vec_count`, `err_count`, `cover_mask` and `first_fail_vec` update at the edge ending CHECK. `mismatch` is high for the cycle after CHECK.
- `done` and `pass` assert on the same edge as the 16th distinct mask bit is set.
- A vector held for fewer than `SETTLE_CYCLES` + 1 cycles is never checked.

## Test plan
- **Reset mid-run**: assert `rst` during SETTLE after 5 checks → all outputs 0 immediately; the FSM is in IDLE.
- **Correct DUT, full coverage**: DUT model correct, `SETTLE_CYCLES`=2; start, then drive vectors 0..15 ascending, each held 5 cycles → `done`=1, `pass`=1, `vec_count`=16, `err_count`=0, `cover_mask`=16'hFFFF, no `mismatch` pulses.
- **Stuck-at fault**: `dut_f` forced to 1, ascending sweep → `err_count`=4 (vectors 3, 7, 11, 15), four `mismatch` pulses, `first_fail_vec`=4'b0011, `pass`=0.
- **Glitch rejection**: hold vector 5 for 2 cycles (`SETTLE_CYCLES`=2), then vector 6 for 5 cycles → only 6 is checked; `vec_count`=1, `cover_mask`=16'h0040.
- **Repeated vectors**: sequence 0, 1, 0, 1 → `vec_count`=4, `cover_mask`=16'h0003, `done`=0; ignored `start` pulses during the run have no effect.
- **Saturation**: `CNT_W`=4, `dut_g` forced to 0, 20 changing vectors → `err_count` and `vec_count` both saturate at 15.
